uart_alu_responder: RTL and testbench
=====================================

Name: uart_alu_responder

Overview:
- Packet engine on the device side of the UART ALU link.
- Consumes the byte stream from the UART receiver, parses command packets, executes echo/add/mul/div and emits response bytes to the UART transmitter.
- It is the responder counterpart to the bench runner that issues echo and fuzz_add/mul/div traffic.
- Sits between uart_rx and uart_tx inside uart_alu.

Parameters:
- OP_ECHO, 8'hEC: echo opcode
- OP_ADD, 8'hAD: 32-bit add-accumulate opcode
- OP_MUL, 8'h88: 32-bit multiply-accumulate opcode
- OP_DIV, 8'hD1: 32-bit signed divide opcode

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- rx_data_i  in  8  byte from UART receiver
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  block accepts rx byte this cycle
- tx_data_o  out  8  byte to UART transmitter
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  transmitter accepts byte
- busy_o  out  1  high in any state other than S_OPCODE
- err_o  out  1  one-cycle pulse on a rejected packet

Behaviour:
- Handshakes: an rx byte transfers when rx_valid_i && rx_ready_o. A tx byte transfers when tx_valid_o && tx_ready_i. Once tx_valid_o is high, tx_data_o holds stable until the transfer.
- Reset: all outputs 0; state S_OPCODE; accumulators, counters and length cleared. Reset mid-packet abandons the packet and drops any pending tx byte.
- Packet format: opcode, reserved byte (ignored), len_lo, len_hi, then len-4 payload bytes. len is the total packet length including the 4 header bytes. Operands are 32-bit, little-endian.
- FSM states: S_OPCODE, S_RSV, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPER, S_MUL, S_DIV, S_RESP, S_DRAIN.
- rx_ready_o is 1 in S_OPCODE, S_RSV, S_LEN_LO, S_LEN_HI, S_OPER and S_DRAIN. In S_ECHO it is 1 only when the tx holding register is empty or being consumed that cycle. It is 0 elsewhere.
- Header validation, performed at the accepted len_hi byte:
  - ECHO: len>=4.
  - ADD and MUL: len>=12 and (len-4)%4==0.
  - DIV: len==12.
  - Any other opcode is invalid.
  - On failure: err_o pulses the next cycle. If len>4, go to S_DRAIN and discard len-4 bytes; otherwise return to S_OPCODE. No response bytes are sent.
- ECHO: each payload byte is copied to the tx holding register (max 1 byte in flight). After the last byte is sent, return to S_OPCODE. len==4 produces no output and returns to S_OPCODE directly.
- ADD: the first operand loads the accumulator. Each later operand is added modulo 2^32 in the cycle its 4th byte is accepted. After the last operand, go to S_RESP.
- MUL: the first operand loads the accumulator. On each later operand's 4th byte, enter S_MUL and run a 32-iteration shift-add (1 bit per cycle), keeping the low 32 bits of the product. rx_ready_o is 0 during S_MUL. Then return to S_OPER, or go to S_RESP after the last operand.
- DIV: operand A is the dividend, operand B the divisor. Signed restoring divide, 32 cycles, quotient truncated toward zero, remainder takes the sign of the dividend.
  - B==0: quotient 32'hFFFFFFFF, remainder = A, completes in 1 cycle.
  - A=32'h80000000, B=-1: quotient 32'h80000000, remainder 0.
- S_RESP:
  - ADD and MUL send 4 bytes of the result, LSB first.
  - DIV sends the quotient (4 bytes) then the remainder (4 bytes), LSB first.
  - Then return to S_OPCODE.
- Latency: the first response byte is valid 1 cycle after the last rx byte is accepted (ADD) or after the compute state finishes (MUL/DIV).
- Back-to-back packets: the next opcode is accepted the cycle after the last response byte transfers. tx_ready_i held low stalls S_RESP indefinitely with no data loss.

Test Plan:
- Echo: send EC 00 08 00 42 69 42 69 -> tx bytes 42 69 42 69; err_o never high; busy_o low afterwards.
- Add with wrap: AD 00 10 00, operands FFFFFFFF, 00000002, 00000005 -> tx 06 00 00 00.
- Mul: 88 00 0C 00, operands 00010000 and 00030000 -> low 32 bits 00000000 -> tx 00 00 00 00. Operands 00000007 and FFFFFFFD -> tx EB FF FF FF.
- Div: D1 00 0C 00, A=-7 (FFFFFFF9), B=2 -> quotient FFFFFFFD, remainder FFFFFFFF. B=0 with A=5 -> FF FF FF FF 05 00 00 00.
- Errors: opcode 0x55 with len=6 -> err_o pulse, 2 bytes drained, no tx. DIV with len=8 -> err_o pulse, no tx. A following valid echo still succeeds.
- Reset/backpressure: hold tx_ready_i=0 for 50 cycles mid-response -> tx_data_o stable, no bytes lost. Assert rst_i mid-MUL -> outputs 0, the next packet is processed correctly.

Source files
------------

// File: rtl/uart_alu_responder_if.sv
// rtl/uart_alu_responder_if.sv - rx/tx byte handshakes and status flags of the UART ALU responder
interface uart_alu_responder_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       err_o;

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
  );
endinterface

// File: rtl/uart_alu_responder.sv
// rtl/uart_alu_responder.sv - parses UART ALU command packets, runs echo/add/mul/div, streams responses
module uart_alu_responder #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'hAD,
  parameter logic [7:0] OP_MUL  = 8'h88,
  parameter logic [7:0] OP_DIV  = 8'hD1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  uart_alu_responder_if.slave bus
);
  typedef enum logic [3:0] {
    S_OPCODE, S_RSV, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPER, S_MUL, S_DIV, S_RESP, S_DRAIN
  } state_t;

  state_t      state;
  logic [7:0]  opcode, len_lo, tx_data;
  logic        tx_valid, err;
  logic [15:0] cnt;
  logic [1:0]  byte_idx;
  logic        first_op, last_op;
  logic [23:0] oper;
  logic [31:0] acc, mul_b, prod;
  logic [31:0] div_a, div_bm, div_q, div_r;
  logic        div_zero, neg_q, neg_r;
  logic [4:0]  iter;
  logic [55:0] resp;
  logic [2:0]  resp_left;

  logic        rdy, rx_fire, tx_fire, len_ok;
  logic [15:0] len, pay_len;
  logic [31:0] word, add_sum, prod_next;
  logic [32:0] rem_w, rem_sub;
  logic        div_ge;
  logic [31:0] rem_next, q_next, q_final, r_final;

  always_comb begin
    rdy = 1'b0;
    case (state)
      S_OPCODE, S_RSV, S_LEN_LO, S_LEN_HI, S_OPER, S_DRAIN: rdy = 1'b1;
      S_ECHO:  rdy = (cnt != 16'd0) && (!tx_valid || bus.tx_ready_i);
      default: rdy = 1'b0;
    endcase
  end

  assign bus.rx_ready_o = rdy && !rst_i;
  assign bus.tx_data_o  = tx_data;
  assign bus.tx_valid_o = tx_valid;
  assign bus.err_o      = err;
  assign bus.busy_o     = (state != S_OPCODE);

  assign rx_fire = bus.rx_valid_i && bus.rx_ready_o;
  assign tx_fire = tx_valid && bus.tx_ready_i;
  assign len     = {bus.rx_data_i, len_lo};
  assign pay_len = len - 16'd4;
  assign word    = {bus.rx_data_i, oper};
  assign add_sum = acc + word;

  always_comb begin
    len_ok = 1'b0;
    if (opcode == OP_ECHO)
      len_ok = (len >= 16'd4);
    else if (opcode == OP_ADD || opcode == OP_MUL)
      len_ok = (len >= 16'd12) && (len[1:0] == 2'b00);
    else if (opcode == OP_DIV)
      len_ok = (len == 16'd12);
  end

  // One shift-add step of the multiply; acc doubles as the shifting multiplicand.
  assign prod_next = prod + (mul_b[0] ? acc : 32'd0);

  // One restoring-divide step on magnitudes; div_q shifts the dividend out and the quotient in.
  assign rem_w    = {div_r, div_q[31]};
  assign rem_sub  = rem_w - {1'b0, div_bm};
  assign div_ge   = (rem_w >= {1'b0, div_bm});
  assign rem_next = div_ge ? rem_sub[31:0] : rem_w[31:0];
  assign q_next   = {div_q[30:0], div_ge};
  assign q_final  = neg_q ? -q_next : q_next;
  assign r_final  = neg_r ? -rem_next : rem_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_OPCODE;
      opcode    <= 8'd0;
      len_lo    <= 8'd0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      err       <= 1'b0;
      cnt       <= 16'd0;
      byte_idx  <= 2'd0;
      first_op  <= 1'b0;
      last_op   <= 1'b0;
      oper      <= 24'd0;
      acc       <= 32'd0;
      mul_b     <= 32'd0;
      prod      <= 32'd0;
      div_a     <= 32'd0;
      div_bm    <= 32'd0;
      div_q     <= 32'd0;
      div_r     <= 32'd0;
      div_zero  <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      iter      <= 5'd0;
      resp      <= 56'd0;
      resp_left <= 3'd0;
    end else begin
      err <= 1'b0;
      if (tx_fire) tx_valid <= 1'b0;
      case (state)
        S_OPCODE: if (rx_fire) begin
          opcode <= bus.rx_data_i;
          state  <= S_RSV;
        end
        S_RSV: if (rx_fire) state <= S_LEN_LO;
        S_LEN_LO: if (rx_fire) begin
          len_lo <= bus.rx_data_i;
          state  <= S_LEN_HI;
        end
        S_LEN_HI: if (rx_fire) begin
          cnt      <= pay_len;
          byte_idx <= 2'd0;
          first_op <= 1'b1;
          if (!len_ok) begin
            err   <= 1'b1;
            state <= (len > 16'd4) ? S_DRAIN : S_OPCODE;
          end else if (opcode == OP_ECHO) begin
            state <= (len == 16'd4) ? S_OPCODE : S_ECHO;
          end else begin
            state <= S_OPER;
          end
        end
        // cnt reaches 0 on the last payload byte; leave once that byte has gone out.
        S_ECHO: begin
          if (rx_fire) begin
            tx_data  <= bus.rx_data_i;
            tx_valid <= 1'b1;
            cnt      <= cnt - 16'd1;
          end else if (cnt == 16'd0 && tx_fire) begin
            state <= S_OPCODE;
          end
        end
        S_DRAIN: if (rx_fire) begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) state <= S_OPCODE;
        end
        S_OPER: if (rx_fire) begin
          oper     <= word[31:8];
          byte_idx <= byte_idx + 2'd1;
          cnt      <= cnt - 16'd1;
          if (byte_idx == 2'd3) begin
            first_op <= 1'b0;
            last_op  <= (cnt == 16'd1);
            if (opcode == OP_DIV) begin
              if (first_op) begin
                div_a <= word;
              end else begin
                neg_q    <= div_a[31] ^ word[31];
                neg_r    <= div_a[31];
                div_zero <= (word == 32'd0);
                div_bm   <= word[31] ? -word : word;
                div_q    <= div_a[31] ? -div_a : div_a;
                div_r    <= 32'd0;
                iter     <= 5'd0;
                state    <= S_DIV;
              end
            end else if (first_op) begin
              acc <= word;
            end else if (opcode == OP_MUL) begin
              mul_b <= word;
              prod  <= 32'd0;
              iter  <= 5'd0;
              state <= S_MUL;
            end else begin
              acc <= add_sum;
              if (cnt == 16'd1) begin
                tx_data   <= add_sum[7:0];
                tx_valid  <= 1'b1;
                resp      <= {24'd0, add_sum[31:8]};
                resp_left <= 3'd3;
                state     <= S_RESP;
              end
            end
          end
        end
        S_MUL: begin
          prod  <= prod_next;
          acc   <= acc << 1;
          mul_b <= mul_b >> 1;
          iter  <= iter + 5'd1;
          if (iter == 5'd31) begin
            acc <= prod_next;
            if (last_op) begin
              tx_data   <= prod_next[7:0];
              tx_valid  <= 1'b1;
              resp      <= {24'd0, prod_next[31:8]};
              resp_left <= 3'd3;
              state     <= S_RESP;
            end else begin
              state <= S_OPER;
            end
          end
        end
        S_DIV: begin
          if (div_zero) begin
            tx_data   <= 8'hFF;
            tx_valid  <= 1'b1;
            resp      <= {div_a, 24'hFFFFFF};
            resp_left <= 3'd7;
            state     <= S_RESP;
          end else begin
            div_r <= rem_next;
            div_q <= q_next;
            iter  <= iter + 5'd1;
            if (iter == 5'd31) begin
              tx_data   <= q_final[7:0];
              tx_valid  <= 1'b1;
              resp      <= {r_final, q_final[31:8]};
              resp_left <= 3'd7;
              state     <= S_RESP;
            end
          end
        end
        S_RESP: if (tx_fire) begin
          if (resp_left == 3'd0) begin
            state <= S_OPCODE;
          end else begin
            tx_data   <= resp[7:0];
            tx_valid  <= 1'b1;
            resp      <= resp >> 8;
            resp_left <= resp_left - 3'd1;
          end
        end
        default: state <= S_OPCODE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_responder.sv
// tb/tb_uart_alu_responder.sv - directed packet sequence with a tx byte scoreboard for uart_alu_responder
module tb_uart_alu_responder;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   err_seen;
  int   stall_after;
  bit   drv_done;
  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];

  uart_alu_responder_if ifc ();

  uart_alu_responder dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hdr(input logic [7:0] op, input logic [15:0] len);
    pkt_q.delete();
    pkt_q.push_back(op);
    pkt_q.push_back(8'h00);
    pkt_q.push_back(len[7:0]);
    pkt_q.push_back(len[15:8]);
  endtask

  task automatic op32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) pkt_q.push_back(w[8*i +: 8]);
  endtask

  task automatic exp32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // Entered at posedge+1; leaves at posedge+1 after the last byte has been accepted.
  task automatic send_pkt();
    int n;
    foreach (pkt_q[i]) begin
      ifc.rx_data_i  = pkt_q[i];
      ifc.rx_valid_i = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ifc.rx_ready_o && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (!ifc.rx_ready_o) chk("rx_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    ifc.rx_valid_i = 1'b0;
  endtask

  task automatic do_stall();
    int bad = 0;
    @(posedge clk);
    #1;
    ifc.tx_ready_i = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!ifc.tx_valid_o || exp_q.size() == 0 || ifc.tx_data_o !== exp_q[0]) bad++;
    end
    chk("stall_hold_cycles_bad", bad, 0);
    @(posedge clk);
    #1;
    ifc.tx_ready_i = 1'b1;
  endtask

  task automatic collect();
    int  cyc = 0;
    int  popped = 0;
    bit  done = 0;
    logic [7:0] e;
    err_seen = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (ifc.err_o) err_seen++;
      if (ifc.tx_valid_o && ifc.tx_ready_i) begin
        chk("tx_byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_byte", ifc.tx_data_o, e);
          popped++;
          if (popped == stall_after) do_stall();
        end
      end
      if (drv_done && exp_q.size() == 0 && !ifc.busy_o && !ifc.tx_valid_o) done = 1;
    end
    chk("packet_completes", done, 1);
  endtask

  task automatic run_pkt(input string tag, input int exp_err);
    drv_done = 0;
    fork
      begin
        send_pkt();
        drv_done = 1;
      end
      collect();
    join
    chk({tag, "_err_pulses"}, err_seen, exp_err);
    chk({tag, "_busy_after"}, ifc.busy_o, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    ifc.rx_data_i  = 8'h00;
    ifc.rx_valid_i = 1'b0;
    ifc.tx_ready_i = 1'b1;
    stall_after    = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_valid", ifc.tx_valid_o, 0);
    chk("reset_tx_data", ifc.tx_data_o, 0);
    chk("reset_busy", ifc.busy_o, 0);
    chk("reset_err", ifc.err_o, 0);
    chk("reset_rx_ready", ifc.rx_ready_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", ifc.rx_ready_o, 1);
    @(posedge clk);
    #1;

    hdr(8'hEC, 16'd8);
    pkt_q.push_back(8'h42); pkt_q.push_back(8'h69); pkt_q.push_back(8'h42); pkt_q.push_back(8'h69);
    exp_q.push_back(8'h42); exp_q.push_back(8'h69); exp_q.push_back(8'h42); exp_q.push_back(8'h69);
    run_pkt("echo4", 0);

    hdr(8'hAD, 16'd16);
    op32(32'hFFFFFFFF); op32(32'h00000002); op32(32'h00000005);
    exp32(32'h00000006);
    run_pkt("add_wrap", 0);

    hdr(8'hAD, 16'd12);
    op32(32'h12345678); op32(32'h11111111);
    exp32(32'h23456789);
    run_pkt("add_two", 0);

    hdr(8'h88, 16'd12);
    op32(32'h00010000); op32(32'h00030000);
    exp32(32'h00000000);
    run_pkt("mul_overflow", 0);

    hdr(8'h88, 16'd12);
    op32(32'h00000007); op32(32'hFFFFFFFD);
    exp32(32'hFFFFFFEB);
    run_pkt("mul_neg", 0);

    hdr(8'hD1, 16'd12);
    op32(32'hFFFFFFF9); op32(32'h00000002);
    exp32(32'hFFFFFFFD); exp32(32'hFFFFFFFF);
    run_pkt("div_neg", 0);

    hdr(8'hD1, 16'd12);
    op32(32'h00000005); op32(32'h00000000);
    exp32(32'hFFFFFFFF); exp32(32'h00000005);
    run_pkt("div_zero", 0);

    hdr(8'hD1, 16'd12);
    op32(32'h80000000); op32(32'hFFFFFFFF);
    exp32(32'h80000000); exp32(32'h00000000);
    run_pkt("div_ovf", 0);

    hdr(8'h55, 16'd6);
    pkt_q.push_back(8'h11); pkt_q.push_back(8'h22);
    run_pkt("bad_opcode", 1);

    hdr(8'hD1, 16'd8);
    op32(32'h00000009);
    run_pkt("div_len8", 1);

    hdr(8'hEC, 16'd5);
    pkt_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    run_pkt("echo_after_err", 0);

    hdr(8'hEC, 16'd4);
    run_pkt("echo_empty", 0);

    stall_after = 3;
    hdr(8'hD1, 16'd12);
    op32(32'h00000064); op32(32'hFFFFFFF9);
    exp32(32'hFFFFFFF2); exp32(32'h00000002);
    run_pkt("div_backpressure", 0);
    stall_after = -1;

    hdr(8'h88, 16'd12);
    op32(32'h00000003); op32(32'h00000005);
    send_pkt();
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mul_busy_before_reset", ifc.busy_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midmul_reset_tx_valid", ifc.tx_valid_o, 0);
    chk("midmul_reset_tx_data", ifc.tx_data_o, 0);
    chk("midmul_reset_busy", ifc.busy_o, 0);
    chk("midmul_reset_err", ifc.err_o, 0);
    chk("midmul_reset_rx_ready", ifc.rx_ready_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    hdr(8'h88, 16'd16);
    op32(32'h00000002); op32(32'h00000003); op32(32'h00000004);
    exp32(32'h00000018);
    run_pkt("mul_after_reset", 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
